// File: rtl/led_mode_sequencer.sv
// 6-LED pattern sequencer with debounced mode/speed buttons and a speed-scaled step prescaler.
// Optional build macro LED_SEQ_PAUSE_EN: pressing both buttons toggles a pause that freezes the display.
module led_mode_sequencer #(
    parameter int unsigned STEP_CYCLES_BASE = 4500000,
    parameter int unsigned DEBOUNCE_CYCLES  = 270000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode_n,
    input  logic       btn_speed_n,
    output logic [5:0] leds,
    output logic [1:0] mode,
    output logic [1:0] speed
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'd0, BOUNCE = 2'd1, FILL = 2'd2, BLINK = 2'd3} mode_t;

    mode_t       mode_q;
    logic [2:0]  pos;
    logic        dir_up;
    logic [2:0]  k;
    logic        phase;
    logic [31:0] presc;
    logic [31:0] period;
    logic        tick;
    logic        paused;
    logic        act_mode;
    logic        act_speed;

    // Bit 0 = mode button, bit 1 = speed button; levels kept in raw polarity (1 = released)
    logic [1:0]    raw;
    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [1:0]    accepted;
    logic [1:0]    accepted_last;
    logic [1:0]    fall;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    assign raw  = {btn_speed_n, btn_mode_n};
    assign fall = accepted_last & ~accepted;
    assign mode = mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0       <= 2'b11;
            sync_p1       <= 2'b11;
            accepted      <= 2'b11;
            accepted_last <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0       <= raw;
            sync_p1       <= sync_p0;
            accepted_last <= accepted;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
                    accepted[i] <= sync_p1[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef LED_SEQ_PAUSE_EN
    // A button newly accepted as pressed while the other is already held forms a chord
    logic [1:0] chord;
    assign chord = fall & {~accepted_last[0], ~accepted_last[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            paused <= 1'b0;
            press  <= 2'b00;
        end else begin
            if (|chord) paused <= ~paused;
            press <= fall & ~chord;
        end
    end
`else
    assign paused = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) press <= 2'b00;
        else       press <= fall;
    end
`endif

    assign act_mode  = press[0] & ~paused;
    assign act_speed = press[1] & ~paused;
    assign period    = 32'(STEP_CYCLES_BASE) << speed;
    assign tick      = (presc == period - 32'd1) && !paused;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= RUN;
            speed  <= 2'd0;
            presc  <= '0;
            pos    <= 3'd0;
            dir_up <= 1'b1;
            k      <= 3'd0;
            phase  <= 1'b0;
        end else begin
            if (act_mode || act_speed || tick) presc <= '0;
            else if (!paused)                  presc <= presc + 32'd1;

            if (act_speed) speed <= speed + 2'd1;

            // A mode change restarts the pattern and swallows any tick in the same cycle
            if (act_mode) begin
                mode_q <= mode_t'(mode_q + 2'd1);
                pos    <= 3'd0;
                dir_up <= 1'b1;
                k      <= 3'd0;
                phase  <= 1'b0;
            end else if (tick) begin
                case (mode_q)
                    RUN:    pos <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
                    BOUNCE: begin
                        if (dir_up) begin
                            if (pos == 3'd5) begin
                                pos    <= 3'd4;
                                dir_up <= 1'b0;
                            end else begin
                                pos <= pos + 3'd1;
                            end
                        end else begin
                            if (pos == 3'd0) begin
                                pos    <= 3'd1;
                                dir_up <= 1'b1;
                            end else begin
                                pos <= pos - 3'd1;
                            end
                        end
                    end
                    FILL:   k <= (k == 3'd6) ? 3'd0 : k + 3'd1;
                    BLINK:  phase <= ~phase;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        logic [5:0] pattern;
        pattern = 6'b000000;
        case (mode_q)
            RUN, BOUNCE: pattern = 6'd1 << pos;
            FILL:        pattern = 6'((7'd1 << k) - 7'd1);
            BLINK:       pattern = phase ? 6'b000000 : 6'b111111;
            default:     pattern = 6'b000000;
        endcase
        leds = ~pattern;
    end
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Scoreboard bench for led_mode_sequencer: a tick-count model predicts leds/mode/speed every cycle.
module tb_led_mode_sequencer;
    localparam int STEP = 4;
    localparam int DEB  = 3;
    localparam int LAT  = DEB + 4;   // edge of first low sample -> edge where the press takes effect

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode_n = 1'b1;
    logic       btn_speed_n = 1'b1;
    logic [5:0] leds;
    logic [1:0] mode;
    logic [1:0] speed;

    led_mode_sequencer #(.STEP_CYCLES_BASE(STEP), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .btn_mode_n(btn_mode_n), .btn_speed_n(btn_speed_n),
        .leds(leds), .mode(mode), .speed(speed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] leds;
        logic [1:0] mode;
        logic [1:0] speed;
        int         edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;
    bit   mode_ev[int];
    bit   speed_ev[int];
    int   e = 0;
    int   m_mode = 0, m_speed = 0, m_n = 0, m_cnt = 0;

    // Display as a function of how many steps have elapsed since the pattern restarted
    function automatic logic [5:0] model_leds(input int md, input int n);
        int v;
        logic [5:0] p;
        case (md)
            0: p = 6'(1 << (n % 6));
            1: begin
                v = n % 10;
                p = 6'(1 << ((v <= 5) ? v : 10 - v));
            end
            2: p = 6'((1 << (n % 7)) - 1);
            default: p = ((n % 2) == 1) ? 6'h00 : 6'h3f;
        endcase
        return ~p;
    endfunction

    task automatic cycle();
        bit pm, ps, tk;
        @(posedge clk);
        if (reset) begin
            m_mode = 0; m_speed = 0; m_n = 0; m_cnt = 0;
        end else begin
            pm = mode_ev.exists(e);
            ps = speed_ev.exists(e);
            tk = (m_cnt == (STEP << m_speed) - 1);
            if (pm || ps || tk) m_cnt = 0;
            else                m_cnt++;
            if (ps) m_speed = (m_speed + 1) % 4;
            if (pm) begin
                m_mode = (m_mode + 1) % 4;
                m_n = 0;
            end else if (tk) begin
                m_n++;
            end
        end
        sb.push_back('{model_leds(m_mode, m_n), 2'(m_mode), 2'(m_speed), e});
        e++;
        #1;
    endtask

    task automatic press(input bit do_mode, input bit do_speed, input int hold, input int gap);
        if (do_mode) begin
            btn_mode_n = 1'b0;
            mode_ev[e + LAT] = 1'b1;
        end
        if (do_speed) begin
            btn_speed_n = 1'b0;
            speed_ev[e + LAT] = 1'b1;
        end
        repeat (hold) cycle();
        btn_mode_n  = 1'b1;
        btn_speed_n = 1'b1;
        repeat (gap) cycle();
    endtask

    task automatic glitch(input bit on_speed);
        for (int r = 0; r < 2; r++) begin
            if (on_speed) btn_speed_n = 1'b0;
            else          btn_mode_n  = 1'b0;
            repeat ($urandom_range(1, 2)) cycle();
            btn_mode_n  = 1'b1;
            btn_speed_n = 1'b1;
            cycle();
        end
        repeat (8) cycle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            checks++;
            if (leds !== mon_x.leds) begin
                errors++;
                $display("FAIL leds @edge %0d: got %b expected %b", mon_x.edge_no, leds, mon_x.leds);
            end
            checks++;
            if (mode !== mon_x.mode) begin
                errors++;
                $display("FAIL mode @edge %0d: got %0d expected %0d", mon_x.edge_no, mode, mon_x.mode);
            end
            checks++;
            if (speed !== mon_x.speed) begin
                errors++;
                $display("FAIL speed @edge %0d: got %0d expected %0d", mon_x.edge_no, speed, mon_x.speed);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        repeat (30) cycle();

        press(1'b1, 1'b0, 10, 10);
        repeat (50) cycle();
        press(1'b1, 1'b0, 8, 10);
        repeat (40) cycle();

        repeat (3) press(1'b0, 1'b1, 8, 10);
        repeat (100) cycle();
        press(1'b0, 1'b1, 8, 10);
        repeat (20) cycle();

        btn_mode_n = 1'b0; repeat (2) cycle();
        btn_mode_n = 1'b1; cycle();
        btn_mode_n = 1'b0; repeat (2) cycle();
        btn_mode_n = 1'b1; repeat (10) cycle();
        press(1'b1, 1'b0, 100, 15);

        repeat (3) press(1'b1, 1'b0, 7, 9);
        repeat (2) press(1'b0, 1'b1, 7, 9);
        repeat (40) cycle();
        pulse_reset();
        repeat (30) cycle();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: repeat ($urandom_range(1, 40)) cycle();
                1: press(1'b1, 1'b0, $urandom_range(6, 20), $urandom_range(8, 30));
                2: press(1'b0, 1'b1, $urandom_range(6, 20), $urandom_range(8, 30));
                3: press(1'b1, 1'b1, $urandom_range(6, 20), $urandom_range(8, 30));
                4: glitch(1'($urandom_range(0, 1)));
                default: begin
                    if ($urandom_range(0, 3) == 0) pulse_reset();
                    repeat ($urandom_range(1, 10)) cycle();
                end
            endcase
        end

        repeat (5) cycle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
